// File: rtl/rsa_pkg.sv
// Shared types and helpers for the sequential RSA modular-exponentiation engine.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        SQR,
        MUL,
        FIN
    } state_t;

    // Edges from the start-sampling edge to the done edge on the normal path.
    function automatic logic [31:0] latency(input int unsigned w);
        return (w + 1) * (2 * w + 1) + 1;
    endfunction

endpackage

// File: rtl/mod_mult_serial.sv
// Interleaved shift-add modular multiplier: p = a*b mod n, MSB of b first.
// go is sampled on an edge; W bit steps follow and rdy pulses with the last one.
module mod_mult_serial #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         rdy,
    output logic [W-1:0] p
);
    localparam int CW = $clog2(W);

    logic [W+1:0]  acc_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  n_reg;
    logic [CW-1:0] cnt_reg;
    logic [W+1:0]  acc_next;

    // With a < n and acc < n the sum stays below 3n, so two subtractions suffice.
    function automatic logic [W+1:0] step(input logic [W+1:0] acc_v, input logic bit_v,
                                          input logic [W-1:0] a_v, input logic [W-1:0] n_v);
        logic [W+1:0] t;
        logic [W+1:0] nn;
        nn = {2'b00, n_v};
        t  = {acc_v[W:0], 1'b0} + (bit_v ? {2'b00, a_v} : '0);
        if (t >= nn) t = t - nn;
        if (t >= nn) t = t - nn;
        return t;
    endfunction

    assign acc_next = step(acc_reg, b_reg[W-1], a_reg, n_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            n_reg   <= '0;
            cnt_reg <= '0;
            busy    <= 1'b0;
            rdy     <= 1'b0;
            p       <= '0;
        end else begin
            rdy <= 1'b0;
            if (!busy && go) begin
                // First step uses the live operands; the rest come from the latched copies.
                acc_reg <= step('0, b[W-1], a, n);
                a_reg   <= a;
                b_reg   <= {b[W-2:0], 1'b0};
                n_reg   <= n;
                cnt_reg <= CW'(W - 1);
                busy    <= 1'b1;
            end else if (busy) begin
                acc_reg <= acc_next;
                b_reg   <= {b_reg[W-2:0], 1'b0};
                cnt_reg <= cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) begin
                    busy <= 1'b0;
                    rdy  <= 1'b1;
                    p    <= acc_next[W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/rsa_modexp_seq.sv
// Constant-time square-and-always-multiply modular exponentiation C = P^e mod n,
// sharing one serial modular multiplier across reduction, squaring and multiply.
module rsa_modexp_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] P,
    input  logic [W-1:0] e,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] C,
    output logic         err
);
    import rsa_pkg::*;

    localparam int IW = $clog2(W);

    state_t        state_reg;
    logic [W-1:0]  p_reg;
    logic [W-1:0]  e_reg;
    logic [W-1:0]  n_reg;
    logic [W-1:0]  r_reg;
    logic [W-1:0]  base_reg;
    logic [IW-1:0] i_reg;
    logic          go_reg;
    logic          short_reg;
    logic          hold_reg;
    logic [31:0]   lat_cnt_reg;

    logic [W-1:0]  mult_a;
    logic [W-1:0]  mult_b;
    logic          mult_busy;
    logic          mult_rdy;
    logic [W-1:0]  mult_p;

    // REDUCE multiplies 1*P to get P mod n even when P >= n.
    always_comb begin
        mult_a = r_reg;
        mult_b = r_reg;
        case (state_reg)
            REDUCE:  begin mult_a = W'(1);   mult_b = p_reg; end
            MUL:     begin mult_a = base_reg; mult_b = r_reg; end
            default: begin mult_a = r_reg;   mult_b = r_reg; end
        endcase
    end

    mod_mult_serial #(.W(W)) u_mult (
        .clk  (clk),
        .rst  (rst),
        .go   (go_reg),
        .a    (mult_a),
        .b    (mult_b),
        .n    (n_reg),
        .busy (mult_busy),
        .rdy  (mult_rdy),
        .p    (mult_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            p_reg       <= '0;
            e_reg       <= '0;
            n_reg       <= '0;
            r_reg       <= '0;
            base_reg    <= '0;
            i_reg       <= '0;
            go_reg      <= 1'b0;
            short_reg   <= 1'b0;
            hold_reg    <= 1'b0;
            lat_cnt_reg <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            C           <= '0;
            err         <= 1'b0;
        end else begin
            done   <= 1'b0;
            go_reg <= 1'b0;
            if (busy) lat_cnt_reg <= lat_cnt_reg + 1'b1;
            assert (!(go_reg && mult_busy));
            case (state_reg)
                IDLE: if (start) begin
                    p_reg       <= P;
                    e_reg       <= e;
                    n_reg       <= n;
                    i_reg       <= IW'(W - 1);
                    r_reg       <= W'(1);
                    busy        <= 1'b1;
                    err         <= 1'b0;
                    lat_cnt_reg <= 32'd1;
                    if (n >= W'(2)) begin
                        state_reg <= REDUCE;
                        go_reg    <= 1'b1;
                        short_reg <= 1'b0;
                    end else begin
                        state_reg <= FIN;
                        short_reg <= 1'b1;
                        hold_reg  <= 1'b1;
                    end
                end
                REDUCE: if (mult_rdy) begin
                    base_reg  <= mult_p;
                    state_reg <= SQR;
                    go_reg    <= 1'b1;
                end
                SQR: if (mult_rdy) begin
                    r_reg     <= mult_p;
                    state_reg <= MUL;
                    go_reg    <= 1'b1;
                end
                MUL: if (mult_rdy) begin
                    // The product is always computed; only the commit depends on e[i].
                    if (e_reg[i_reg]) r_reg <= mult_p;
                    if (i_reg == '0) begin
                        state_reg <= FIN;
                    end else begin
                        i_reg     <= i_reg - 1'b1;
                        state_reg <= SQR;
                        go_reg    <= 1'b1;
                    end
                end
                FIN: if (hold_reg) begin
                    hold_reg <= 1'b0;
                end else begin
                    assert (short_reg || lat_cnt_reg == latency(W));
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    C         <= short_reg ? '0 : r_reg;
                    err       <= short_reg && (n_reg == '0);
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Directed and random checks of rsa_modexp_seq at W=8 and W=16.
module tb_rsa_modexp_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  P8 = '0, e8 = '0, n8 = '0;
    logic        busy8, done8, err8;
    logic [7:0]  C8;

    logic        start16 = 1'b0;
    logic [15:0] P16 = '0, e16 = '0, n16 = '0;
    logic        busy16, done16, err16;
    logic [15:0] C16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rsa_modexp_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .P(P8), .e(e8), .n(n8),
        .busy(busy8), .done(done8), .C(C8), .err(err8)
    );

    rsa_modexp_seq #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .P(P16), .e(e16), .n(n16),
        .busy(busy16), .done(done16), .C(C16), .err(err16)
    );

    function automatic longint ref_modexp(input longint p, input longint ee, input longint nn);
        longint r, b, x;
        r = 1;
        b = p % nn;
        x = ee;
        while (x > 0) begin
            if ((x & 1) != 0) r = (r * b) % nn;
            b = (b * b) % nn;
            x = x >> 1;
        end
        return r % nn;
    endfunction

    // Issue one W=8 operation and wait for done; lat is -1 on timeout.
    task automatic run8(input logic [7:0] p, input logic [7:0] ee, input logic [7:0] nn,
                        output logic [7:0] c, output logic er, output logic er_early,
                        output int lat, output logic busy_ok);
        busy_ok = 1'b1; lat = -1; er_early = 1'bx;
        P8 = p; e8 = ee; n8 = nn; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk); #1;
            if (k == 1) er_early = err8;
            if (done8) begin
                lat = k;
                if (busy8) busy_ok = 1'b0;
                break;
            end
            if (!busy8) busy_ok = 1'b0;
        end
        c = C8; er = err8;
    endtask

    task automatic run16(input logic [15:0] p, input logic [15:0] ee, input logic [15:0] nn,
                         output logic [15:0] c, output int lat);
        lat = -1;
        P16 = p; e16 = ee; n16 = nn; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk); #1;
            if (done16) begin
                lat = k;
                break;
            end
        end
        c = C16;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy8, done8, err8} !== 3'b000) begin errors++; $display("FAIL reset_flags8 got %b want 000", {busy8, done8, err8}); end
        checks++; if (C8 !== 8'd0) begin errors++; $display("FAIL reset_C8 got %0d want 0", C8); end
        checks++; if ({busy16, done16, err16} !== 3'b000) begin errors++; $display("FAIL reset_flags16 got %b want 000", {busy16, done16, err16}); end
        checks++; if (C16 !== 16'd0) begin errors++; $display("FAIL reset_C16 got %0d want 0", C16); end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset: busy8=%b done8=%b C8=%0d busy16=%b C16=%0d", busy8, done8, C8, busy16, C16);
    endtask

    task automatic test_basic8();
        logic [7:0] c; logic er, ee, bo; int lat;
        run8(8'd2, 8'd7, 8'd33, c, er, ee, lat, bo);
        $display("basic8: P=2 e=7 n=33 -> C=%0d err=%b lat=%0d", c, er, lat);
        checks++; if (c !== 8'd29) begin errors++; $display("FAIL basic8_C got %0d want 29", c); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic8_err got %b want 0", er); end
        checks++; if (lat !== 154) begin errors++; $display("FAIL basic8_latency got %0d want 154", lat); end
        checks++; if (bo !== 1'b1) begin errors++; $display("FAIL basic8_busy got %b want 1", bo); end
        @(posedge clk); #1;
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic8_done_pulse got %b want 0", done8); end
        checks++; if (C8 !== 8'd29) begin errors++; $display("FAIL basic8_C_hold got %0d want 29", C8); end
    endtask

    task automatic test_vectors8();
        logic [7:0] tp [3] = '{8'd29, 8'd200, 8'd5};
        logic [7:0] te [3] = '{8'd3, 8'd1, 8'd0};
        logic [7:0] tc [3] = '{8'd2, 8'd2, 8'd1};
        logic [7:0] c; logic er, ee, bo; int lat;
        for (int v = 0; v < 3; v++) begin
            run8(tp[v], te[v], 8'd33, c, er, ee, lat, bo);
            $display("vec8: P=%0d e=%0d n=33 -> C=%0d lat=%0d", tp[v], te[v], c, lat);
            checks++; if (c !== tc[v]) begin errors++; $display("FAIL vec8_C%0d got %0d want %0d", v, c, tc[v]); end
            checks++; if (lat !== 154) begin errors++; $display("FAIL vec8_latency%0d got %0d want 154", v, lat); end
        end
    endtask

    task automatic test_short8();
        logic [7:0] c; logic er, ee, bo; int lat;
        run8(8'd7, 8'd5, 8'd1, c, er, ee, lat, bo);
        $display("short8: n=1 -> C=%0d err=%b lat=%0d", c, er, lat);
        checks++; if ({c, er} !== 9'd0) begin errors++; $display("FAIL short8_n1 got C=%0d err=%b want C=0 err=0", c, er); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL short8_n1_latency got %0d want 2", lat); end
        run8(8'd7, 8'd5, 8'd0, c, er, ee, lat, bo);
        $display("short8: n=0 -> C=%0d err=%b lat=%0d", c, er, lat);
        checks++; if (c !== 8'd0 || er !== 1'b1) begin errors++; $display("FAIL short8_n0 got C=%0d err=%b want C=0 err=1", c, er); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL short8_n0_latency got %0d want 2", lat); end
        run8(8'd2, 8'd7, 8'd33, c, er, ee, lat, bo);
        $display("short8: recover n=33 -> C=%0d err_early=%b err=%b", c, ee, er);
        checks++; if (ee !== 1'b0) begin errors++; $display("FAIL short8_err_clear got %b want 0", ee); end
        checks++; if (c !== 8'd29 || er !== 1'b0) begin errors++; $display("FAIL short8_recover got C=%0d err=%b want 29/0", c, er); end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        P8 = 8'd2; e8 = 8'd7; n8 = 8'd33; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk); #1;
            if (k == 49) begin P8 = 8'd5; e8 = 8'd0; n8 = 8'd1; start8 = 1'b1; end
            if (k == 50) start8 = 1'b0;
            if (done8) begin lat = k; break; end
        end
        $display("ignore_start: C=%0d lat=%0d", C8, lat);
        checks++; if (C8 !== 8'd29) begin errors++; $display("FAIL ignore_start_C got %0d want 29", C8); end
        checks++; if (lat !== 154) begin errors++; $display("FAIL ignore_start_latency got %0d want 154", lat); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] c; logic er, ee, bo; int lat; int spurious = 0;
        P8 = 8'd2; e8 = 8'd7; n8 = 8'd33; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (done8) spurious++;
            if (k == 79) rst = 1'b1;
        end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy8); end
        rst = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (done8) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", spurious); end
        run8(8'd2, 8'd7, 8'd33, c, er, ee, lat, bo);
        $display("reset_abort: spurious=%0d then C=%0d lat=%0d", spurious, c, lat);
        checks++; if (c !== 8'd29 || lat !== 154) begin errors++; $display("FAIL abort_restart got C=%0d lat=%0d want 29/154", c, lat); end
    endtask

    task automatic test_rst_start_same();
        P8 = 8'd2; e8 = 8'd7; n8 = 8'd33;
        rst = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start8 = 1'b0;
        $display("rst_start_same: busy8=%b", busy8);
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %b want 0", busy8); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL rst_start_idle got busy=%b done=%b want 0/0", busy8, done8); end
    endtask

    task automatic test_basic16();
        logic [15:0] c; int lat;
        run16(16'd2, 16'd7, 16'd33, c, lat);
        $display("basic16: P=2 e=7 n=33 -> C=%0d lat=%0d", c, lat);
        checks++; if (c !== 16'd29) begin errors++; $display("FAIL basic16_C got %0d want 29", c); end
        checks++; if (lat !== 562) begin errors++; $display("FAIL basic16_latency got %0d want 562", lat); end
    endtask

    task automatic test_random8();
        logic [7:0] p, ee, nn, c, want; logic er, ea, bo; int lat;
        for (int v = 0; v < 100; v++) begin
            p = 8'($urandom_range(0, 255)); ee = 8'($urandom_range(0, 255)); nn = 8'($urandom_range(2, 255));
            want = 8'(ref_modexp(longint'(p), longint'(ee), longint'(nn)));
            run8(p, ee, nn, c, er, ea, lat, bo);
            $display("rand8 %0d: P=%0d e=%0d n=%0d -> C=%0d want %0d lat=%0d", v, p, ee, nn, c, want, lat);
            checks++; if (c !== want || lat !== 154) begin errors++; $display("FAIL rand8_%0d got C=%0d lat=%0d want %0d/154", v, c, lat, want); end
        end
    endtask

    task automatic test_random16();
        logic [15:0] p, ee, nn, c, want; int lat;
        for (int v = 0; v < 100; v++) begin
            p = 16'($urandom_range(0, 65535)); ee = 16'($urandom_range(0, 65535)); nn = 16'($urandom_range(2, 65535));
            want = 16'(ref_modexp(longint'(p), longint'(ee), longint'(nn)));
            run16(p, ee, nn, c, lat);
            $display("rand16 %0d: P=%0d e=%0d n=%0d -> C=%0d want %0d lat=%0d", v, p, ee, nn, c, want, lat);
            checks++; if (c !== want || lat !== 562) begin errors++; $display("FAIL rand16_%0d got C=%0d lat=%0d want %0d/562", v, c, lat, want); end
        end
    endtask

    initial begin
        test_reset();
        test_basic8();
        test_vectors8();
        test_short8();
        test_ignore_start();
        test_reset_abort();
        test_rst_start_same();
        test_basic16();
        test_random8();
        test_random16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
